pipe_fwd_chain: RTL
===================

// Module: pipe_fwd_chain
// PURPOSE
//  Parametrised in-order pipeline latch chain for the RISC-V core. It replaces
//  the hand-instantiated per-stage Register/RegisterEmpty sets (EX/MEM/WB).
//  Carries rd, reg_we, result data and meta bits through STAGES stages, with
//  stall-and-bubble, per-stage flush and late result fill (load data).
//  Also provides a two-port forwarding lookup with load-use busy detection.
// PARAMETERS
//  DW      32  result data width
//  RW      5   register address width
//  MW      8   meta/control payload width (opaque, carried unchanged)
//  STAGES  3   number of chain stages, >=2; IW=$clog2(STAGES), OW=$clog2(STAGES+1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  in_valid   in   1       entry presented to stage 0
//  in_rd      in   RW      destination register
//  in_reg_we  in   1       entry writes register file
//  in_data    in   DW      result value (meaningful only if in_data_ok=1)
//  in_data_ok in   1       result already known at entry
//  in_meta    in   MW      opaque control bits
//  stall      in   1       hold stage 0, insert bubble into stage 1
//  flush      in   STAGES  bit i kills current occupant of stage i
//  late_valid in   1       late result write enable
//  late_idx   in   IW      stage holding target entry
//  late_data  in   DW      late result value
//  q_rs1      in   RW      forward query 1 source register
//  q_rs2      in   RW      forward query 2 source register
//  q1_hit     out  1       / q2_hit: a producing entry matches
//  q1_busy    out  1       / q2_busy: match found but result not yet known
//  q1_data    out  DW      / q2_data: forwarded value, 0 when no hit or busy
//  out_valid  out  1       / out_rd RW, out_reg_we 1, out_data DW, out_meta MW
//  occ        out  OW      count of valid stages, registered
// BEHAVIOUR
//  - Reset (rst=0 at edge): all stage valid/data_ok/fields cleared to 0;
//    occ=0; out_* = 0; q*_hit/busy/data = 0. Reset overrides every other input.
//  - Stage state S[i] = {v, rd, we, data, ok, meta}; out_* = S[STAGES-1] (registered).
//  - Normal edge: S[0] <= inputs (v = in_valid), S[i] <= S[i-1]. Latency STAGES edges.
//  - stall=1: S[0] holds, S[1].v <= 0, S[2..] advance. in_* ignored while stalled.
//  - flush[i]=1: occupant of stage i does not survive the edge. If it would move,
//    the destination gets v=0. If held (stage 0 under stall), its own v <= 0.
//  - Incoming entry is never affected by flush.
//  - Late fill: late_valid targets the occupant of late_idx. data<=late_data, ok<=1,
//    and the update follows the entry to its next position. Ignored if the target is
//    invalid, flushed the same cycle, or late_idx>=STAGES-1.
//  - Forward lookup (combinational on registered state only; late fill visible
//    next cycle):
//    * rs==0 -> hit=0, busy=0, data=0.
//    * Otherwise pick the youngest (lowest i) stage with v & we & rd==rs: hit=1.
//    * If that stage has ok=1, data=S[i].data and busy=0; else busy=1, data=0.
//    * Older matches never override a younger busy match.
//  - occ <= popcount of next-state valid bits (matches S after the edge).
//  - A retiring entry leaves the last stage unconditionally; there is no back-pressure.
// TESTING (STAGES=3)
//  1 Reset: rst=0 2 cycles with in_valid=1 -> out_valid=0, occ=0, q1_hit=0.
//    Release with idle inputs -> still 0.
//  2 Flow: edge0 inject rd=5 we=1 data=0xAA ok=1 ->
//    occ 1,1,1 after edges 0..2; out_valid=1, out_rd=5, out_data=0xAA after edge 2;
//    occ=0 after edge 3.
//  3 Priority: S0 rd=3 data=0x11, S2 rd=3 data=0x22, q_rs1=3 -> q1_hit=1, q1_data=0x11.
//    q_rs2=0 -> q2_hit=0.
//  4 Load-use: inject rd=7 ok=0, q_rs1=7 -> q1_busy=1.
//    Next cycle late_valid idx=1 data=0x55 -> following cycle q1_busy=0, q1_data=0x55.
//    At exit, out_data=0x55.
//  5 Stall+flush: entry A in S0, B in S1, stall=1 flush=3'b010 ->
//    S0=A held, S1.v=0, B gone (not in S2); occ=1.
//  6 Mid-op reset: fill all 3 stages, pull rst=0 one edge ->
//    all v=0, occ=0, out_valid=0 the next cycle.

Source files
------------

// File: rtl/pipe_fwd_chain.sv
// In-order result latch chain (EX/MEM/WB style) with stall/bubble, per-stage
// flush, late result fill and a two-port forwarding lookup with busy detect.

module pipe_fwd_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nxt_v,
  input  logic [RW-1:0] nxt_rd,
  input  logic          nxt_we,
  input  logic [DW-1:0] nxt_data,
  input  logic          nxt_ok,
  input  logic [MW-1:0] nxt_meta,
  output logic          v,
  output logic [RW-1:0] rd,
  output logic          we,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic [MW-1:0] meta
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      v    <= 1'b0;
      rd   <= '0;
      we   <= 1'b0;
      data <= '0;
      ok   <= 1'b0;
      meta <= '0;
    end else begin
      v    <= nxt_v;
      rd   <= nxt_rd;
      we   <= nxt_we;
      data <= nxt_data;
      ok   <= nxt_ok;
      meta <= nxt_meta;
    end
  end
endmodule

module pipe_fwd_chain #(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int MW     = 8,
  parameter int STAGES = 3,
  parameter int IW     = $clog2(STAGES),
  parameter int OW     = $clog2(STAGES+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_reg_we,
  input  logic [DW-1:0]     in_data,
  input  logic              in_data_ok,
  input  logic [MW-1:0]     in_meta,
  input  logic              stall,
  input  logic [STAGES-1:0] flush,
  input  logic              late_valid,
  input  logic [IW-1:0]     late_idx,
  input  logic [DW-1:0]     late_data,
  input  logic [RW-1:0]     q_rs1,
  input  logic [RW-1:0]     q_rs2,
  output logic              q1_hit,
  output logic              q1_busy,
  output logic [DW-1:0]     q1_data,
  output logic              q2_hit,
  output logic              q2_busy,
  output logic [DW-1:0]     q2_data,
  output logic              out_valid,
  output logic [RW-1:0]     out_rd,
  output logic              out_reg_we,
  output logic [DW-1:0]     out_data,
  output logic [MW-1:0]     out_meta,
  output logic [OW-1:0]     occ
);
  logic [STAGES-1:0]          vld_pipe, we_q, ok_q, nxt_v, nxt_we, nxt_ok;
  logic [STAGES-1:0][RW-1:0]  rd_q, nxt_rd;
  logic [STAGES-1:0][DW-1:0]  data_q, nxt_data;
  logic [STAGES-1:0][MW-1:0]  meta_q, nxt_meta;
  logic [STAGES-2:0][DW-1:0]  eff_data;
  logic [STAGES-2:0]          eff_ok;
  logic [OW-1:0]              occ_nxt;
  logic                       unused_flush;

  // The last stage retires regardless, so its flush bit has nothing to kill.
  assign unused_flush = flush[STAGES-1];

  for (genvar j = 0; j < STAGES-1; j++) begin : g_fill
    logic fill;
    assign fill        = late_valid && (late_idx == IW'(j)) && vld_pipe[j] && !flush[j];
    assign eff_data[j] = fill ? late_data : data_q[j];
    assign eff_ok[j]   = ok_q[j] | fill;
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_stg
    if (j == 0) begin : g_head
      assign nxt_v[0]    = stall ? (vld_pipe[0] & ~flush[0]) : in_valid;
      assign nxt_rd[0]   = stall ? rd_q[0]     : in_rd;
      assign nxt_we[0]   = stall ? we_q[0]     : in_reg_we;
      assign nxt_data[0] = stall ? eff_data[0] : in_data;
      assign nxt_ok[0]   = stall ? eff_ok[0]   : in_data_ok;
      assign nxt_meta[0] = stall ? meta_q[0]   : in_meta;
    end else begin : g_body
      // Stage 1 takes a bubble while stage 0 is held.
      assign nxt_v[j]    = vld_pipe[j-1] & ~flush[j-1] & !(stall && (j == 1));
      assign nxt_rd[j]   = rd_q[j-1];
      assign nxt_we[j]   = we_q[j-1];
      assign nxt_data[j] = eff_data[j-1];
      assign nxt_ok[j]   = eff_ok[j-1];
      assign nxt_meta[j] = meta_q[j-1];
    end

    pipe_fwd_stage #(.DW(DW), .RW(RW), .MW(MW)) u_stg (
      .clk      (clk),
      .rst      (rst),
      .nxt_v    (nxt_v[j]),
      .nxt_rd   (nxt_rd[j]),
      .nxt_we   (nxt_we[j]),
      .nxt_data (nxt_data[j]),
      .nxt_ok   (nxt_ok[j]),
      .nxt_meta (nxt_meta[j]),
      .v        (vld_pipe[j]),
      .rd       (rd_q[j]),
      .we       (we_q[j]),
      .data     (data_q[j]),
      .ok       (ok_q[j]),
      .meta     (meta_q[j])
    );
  end

  assign out_valid  = vld_pipe[STAGES-1];
  assign out_rd     = rd_q[STAGES-1];
  assign out_reg_we = we_q[STAGES-1];
  assign out_data   = data_q[STAGES-1];
  assign out_meta   = meta_q[STAGES-1];

  logic [1:0][RW-1:0] q_rs;
  logic [1:0]         q_hit, q_busy;
  logic [1:0][DW-1:0] q_data;

  assign q_rs = {q_rs2, q_rs1};

  // Scan oldest to youngest so the youngest match is what remains.
  always_comb begin
    q_hit  = '0;
    q_busy = '0;
    q_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (q_rs[p] != '0) begin
        for (int i = STAGES-1; i >= 0; i--) begin
          if (vld_pipe[i] && we_q[i] && (rd_q[i] == q_rs[p])) begin
            q_hit[p]  = 1'b1;
            q_busy[p] = !ok_q[i];
            q_data[p] = ok_q[i] ? data_q[i] : '0;
          end
        end
      end
    end
  end

  assign q1_hit  = q_hit[0];
  assign q1_busy = q_busy[0];
  assign q1_data = q_data[0];
  assign q2_hit  = q_hit[1];
  assign q2_busy = q_busy[1];
  assign q2_data = q_data[1];

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) occ_nxt = occ_nxt + OW'(nxt_v[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) occ <= '0;
    else      occ <= occ_nxt;
  end
endmodule
